mem_sched: RTL and testbench

Memory access scheduler that owns the MAR load strobe and shares the single MAR/RAM path among three requesters: instruction fetch (PC), operand fetch (instruction-register address bytes) and an external DMA/IO port. It arbitrates requests, drives the 16-bit address and active-low `nLm` into the MAR, then holds memory enables for a fixed access window and acknowledges the winner. It sits between the controller-sequencer and the MAR/RAM pair.

---
 rtl/mem_sched_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 55 +++++
 rtl/mem_sched.sv | 138 +++++++++++++
 tb/tb_mem_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the memory access scheduler.
package mem_sched_pkg;

    localparam int unsigned NREQ           = 3;
    localparam int unsigned ID_W           = 2;
    localparam int unsigned CNT_W          = 4;
    localparam int unsigned ACCESS_CYC_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef logic [ID_W-1:0] req_id_t;

    localparam req_id_t REQ_FETCH = 2'd0;
    localparam req_id_t REQ_OPND  = 2'd1;
    localparam req_id_t REQ_DMA   = 2'd2;

    // Successor requester in the 0 -> 1 -> 2 -> 0 ring.
    function automatic req_id_t next_id(input req_id_t id);
        return (id == REQ_DMA) ? REQ_FETCH : req_id_t'(id + 2'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// 3-way requester arbiter: round-robin with MEM_SCHED_RR_EN, fixed priority otherwise.
module rr_arbiter
    import mem_sched_pkg::*;
(
`ifdef MEM_SCHED_RR_EN
    input  logic             CLK,
    input  logic             nCLR,
    input  logic             upd,
    input  req_id_t          upd_id,
`endif
    input  logic [NREQ-1:0]  req,
    output logic             gnt_valid_c,
    output req_id_t          gnt_id_c
);

`ifdef MEM_SCHED_RR_EN
    req_id_t ptr_q;
    req_id_t cand;

    // Pointer moves just past the last winner so it gets lowest priority next.
    always_ff @(posedge CLK) begin
        if (!nCLR) begin
            ptr_q <= REQ_FETCH;
        end else if (upd) begin
            ptr_q <= next_id(upd_id);
        end
    end

    always_comb begin
        gnt_valid_c = 1'b0;
        gnt_id_c    = ptr_q;
        cand        = ptr_q;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!gnt_valid_c && req[cand]) begin
                gnt_valid_c = 1'b1;
                gnt_id_c    = cand;
            end
            cand = next_id(cand);
        end
    end
`else
    always_comb begin
        gnt_valid_c = |req;
        gnt_id_c    = REQ_FETCH;
        if (req[0]) begin
            gnt_id_c = REQ_FETCH;
        end else if (req[1]) begin
            gnt_id_c = REQ_OPND;
        end else if (req[2]) begin
            gnt_id_c = REQ_DMA;
        end
    end
`endif

endmodule

// File: rtl/mem_sched.sv
// MAR/RAM access scheduler for fetch, operand and DMA requesters.
// Build option: MEM_SCHED_RR_EN selects round-robin arbitration (default fixed priority).
module mem_sched
    import mem_sched_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned ACCESS_CYC = ACCESS_CYC_DEF
) (
    input  logic              CLK,
    input  logic              nCLR,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   wr,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [ADDR_W-1:0] mar_din,
    output logic              nLm,
    output logic              nCE,
    output logic              nWE,
    output logic [NREQ-1:0]   ack,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_id_t           win_q, win_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] mar_d;
    logic              nlm_d, nce_d, nwe_d, busy_d;
    logic [NREQ-1:0]   ack_d;

    logic              gnt_valid_c;
    req_id_t           gnt_id_c;
    logic [ADDR_W-1:0] gnt_addr_c;
    logic              gnt_wr_c;

`ifdef MEM_SCHED_RR_EN
    logic upd_c;
    assign upd_c = (state_q == ST_DONE);
`endif

    rr_arbiter u_arb (
`ifdef MEM_SCHED_RR_EN
        .CLK         (CLK),
        .nCLR        (nCLR),
        .upd         (upd_c),
        .upd_id      (win_q),
`endif
        .req         (req),
        .gnt_valid_c (gnt_valid_c),
        .gnt_id_c    (gnt_id_c)
    );

    // Address and write flag of the current arbitration winner.
    always_comb begin
        gnt_addr_c = addr0;
        gnt_wr_c   = wr[0];
        case (gnt_id_c)
            REQ_FETCH: begin gnt_addr_c = addr0; gnt_wr_c = wr[0]; end
            REQ_OPND:  begin gnt_addr_c = addr1; gnt_wr_c = wr[1]; end
            default:   begin gnt_addr_c = addr2; gnt_wr_c = wr[2]; end
        endcase
    end

    // Outputs are computed for the state being entered, then registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        wr_d    = wr_q;
        mar_d   = mar_din;
        nlm_d   = 1'b1;
        nce_d   = 1'b1;
        nwe_d   = 1'b1;
        ack_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_c) begin
                    win_d   = gnt_id_c;
                    wr_d    = gnt_wr_c;
                    mar_d   = gnt_addr_c;
                    nlm_d   = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = CNT_W'(ACCESS_CYC - 1);
                nce_d   = 1'b0;
                nwe_d   = ~wr_q;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    ack_d   = NREQ'(3'b001 << win_q);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                    nce_d = 1'b0;
                    nwe_d = ~wr_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!nCLR) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            win_q   <= REQ_FETCH;
            wr_q    <= 1'b0;
            mar_din <= '0;
            nLm     <= 1'b1;
            nCE     <= 1'b1;
            nWE     <= 1'b1;
            ack     <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            wr_q    <= wr_d;
            mar_din <= mar_d;
            nLm     <= nlm_d;
            nCE     <= nce_d;
            nWE     <= nwe_d;
            ack     <= ack_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_sched.sv
// Self-checking bench for mem_sched: one instance with ACCESS_CYC=2, one with ACCESS_CYC=1.
module tb_mem_sched;

    logic        CLK;
    logic        nCLR;
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [15:0] addr0, addr1, addr2;

    logic [15:0] mar  [2];
    logic        nlm  [2];
    logic        nce  [2];
    logic        nwe  [2];
    logic [2:0]  ack  [2];
    logic        busy [2];

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    mem_sched #(.ADDR_W(16), .ACCESS_CYC(2)) u_a (
        .CLK(CLK), .nCLR(nCLR), .req(req), .wr(wr),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .mar_din(mar[0]), .nLm(nlm[0]), .nCE(nce[0]), .nWE(nwe[0]),
        .ack(ack[0]), .busy(busy[0])
    );

    mem_sched #(.ADDR_W(16), .ACCESS_CYC(1)) u_b (
        .CLK(CLK), .nCLR(nCLR), .req(req), .wr(wr),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .mar_din(mar[1]), .nLm(nlm[1]), .nCE(nce[1]), .nWE(nwe[1]),
        .ack(ack[1]), .busy(busy[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    function automatic int ac_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Transaction model: an accepted request occupies ACCESS_CYC+2 cycles after the accept edge.
    bit          m_act [2] = '{0, 0};
    int          m_t   [2] = '{0, 0};
    int          m_win [2] = '{0, 0};
    int          m_ptr [2] = '{0, 0};
    bit          m_wr  [2] = '{0, 0};
    logic [15:0] m_mar [2] = '{16'h0, 16'h0};

    function automatic int pick(input logic [2:0] r, input int p);
        for (int k = 0; k < 3; k++) begin
            int c;
            c = (p + k) % 3;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    function automatic logic [15:0] addr_of(input int id);
        return (id == 0) ? addr0 : (id == 1) ? addr1 : addr2;
    endfunction

    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (!nCLR) begin
                m_act[i] = 1'b0; m_t[i] = 0; m_mar[i] = 16'h0; m_ptr[i] = 0;
            end else if (!m_act[i]) begin
                if (req != 3'b000) begin
                    m_win[i] = pick(req, m_ptr[i]);
                    m_mar[i] = addr_of(m_win[i]);
                    m_wr[i]  = wr[m_win[i]];
                    m_act[i] = 1'b1;
                    m_t[i]   = 1;
                end
            end else if (m_t[i] == ac_of(i) + 2) begin
                m_act[i] = 1'b0;
`ifdef MEM_SCHED_RR_EN
                m_ptr[i] = (m_win[i] + 1) % 3;
`endif
            end else begin
                m_t[i]++;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                bit ld, ac, dn;
                ld = m_act[i] && (m_t[i] == 1);
                ac = m_act[i] && (m_t[i] >= 2) && (m_t[i] <= ac_of(i) + 1);
                dn = m_act[i] && (m_t[i] == ac_of(i) + 2);
                chk($sformatf("m%0d_nLm", i),  32'(nlm[i]),  32'(!ld));
                chk($sformatf("m%0d_nCE", i),  32'(nce[i]),  32'(!ac));
                chk($sformatf("m%0d_nWE", i),  32'(nwe[i]),  32'(!(ac && m_wr[i])));
                chk($sformatf("m%0d_ack", i),  32'(ack[i]),  dn ? 32'(1 << m_win[i]) : 32'h0);
                chk($sformatf("m%0d_busy", i), 32'(busy[i]), 32'(m_act[i]));
                chk($sformatf("m%0d_mar", i),  32'(mar[i]),  32'(m_mar[i]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic int oh2id(input logic [2:0] a);
        case (a)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 7;
        endcase
    endfunction

    int qa[$];
    int qb[$];
    int ta[$];
    int exp_ord [3];

    initial begin
        nCLR = 1'b0; req = 3'b111; wr = 3'b000;
        addr0 = 16'h0; addr1 = 16'h0; addr2 = 16'h0;
        cyc(1);
        chk_en = 1'b1;
        cyc(1);
        // Reset held two edges with all requests high.
        chk("rst_nLm",  32'(nlm[0]),  32'h1);
        chk("rst_nCE",  32'(nce[0]),  32'h1);
        chk("rst_nWE",  32'(nwe[0]),  32'h1);
        chk("rst_ack",  32'(ack[0]),  32'h0);
        chk("rst_mar",  32'(mar[0]),  32'h0);
        chk("rst_busy", 32'(busy[0]), 32'h0);
        nCLR = 1'b1; req = 3'b000;
        cyc(1);

        // Single fetch read; request dropped after being sampled.
        addr0 = 16'h1234; wr = 3'b000; req = 3'b001;
        cyc(1); req = 3'b000;
        chk("rd_load_nLm", 32'(nlm[0]), 32'h0);
        chk("rd_load_mar", 32'(mar[0]), 32'h1234);
        cyc(1);
        chk("rd_acc_nCE", 32'(nce[0]), 32'h0);
        chk("rd_acc_nWE", 32'(nwe[0]), 32'h1);
        cyc(1);
        chk("rd_ack_b", 32'(ack[1]), 32'h1);
        cyc(1);
        chk("rd_ack_a", 32'(ack[0]), 32'h1);
        cyc(2);

        // DMA write.
        addr2 = 16'hBEEF; wr = 3'b100; req = 3'b100;
        cyc(1); req = 3'b000;
        cyc(1);
        chk("wr_nWE", 32'(nwe[0]), 32'h0);
        chk("wr_nCE", 32'(nce[0]), 32'h0);
        chk("wr_mar", 32'(mar[0]), 32'hBEEF);
        cyc(2);
        chk("wr_ack_a", 32'(ack[0]), 32'h4);
        cyc(2);
        wr = 3'b000;

        // Contention: all requests held.
        addr0 = 16'h0100; addr1 = 16'h0111; addr2 = 16'h0122;
        req = 3'b111;
        for (int k = 1; k <= 15; k++) begin
            @(negedge CLK);
            if (ack[0] != 3'b000) begin qa.push_back(oh2id(ack[0])); ta.push_back(k); end
            if (ack[1] != 3'b000) qb.push_back(oh2id(ack[1]));
        end
        req = 3'b000;
`ifdef MEM_SCHED_RR_EN
        exp_ord = '{0, 1, 2};
`else
        exp_ord = '{0, 0, 0};
`endif
        chk("cont_cnt_a", 32'(qa.size()), 32'd3);
        chk("cont_cnt_b", 32'(qb.size()), 32'd4);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("cont_ord_a%0d", j), 32'(j < qa.size() ? qa[j] : 9), 32'(exp_ord[j]));
            chk($sformatf("cont_ord_b%0d", j), 32'(j < qb.size() ? qb[j] : 9), 32'(exp_ord[j]));
        end
        chk("cont_first_ack", 32'(ta.size() > 0 ? ta[0] : 0), 32'd4);
        chk("cont_spacing", 32'(ta.size() > 1 ? ta[1] - ta[0] : 0), 32'd5);
        cyc(3);

        // Reset during ACCESS, request still pending afterwards.
        addr1 = 16'h0A0A; req = 3'b010;
        cyc(2);
        nCLR = 1'b0;
        cyc(1);
        chk("rma_nCE",  32'(nce[0]),  32'h1);
        chk("rma_ack",  32'(ack[0]),  32'h0);
        chk("rma_mar",  32'(mar[0]),  32'h0);
        chk("rma_busy", 32'(busy[0]), 32'h0);
        nCLR = 1'b1;
        cyc(1);
        req = 3'b000;
        chk("rma_restart_nLm", 32'(nlm[0]), 32'h0);
        chk("rma_restart_mar", 32'(mar[0]), 32'h0A0A);
        cyc(6);

        // ACCESS_CYC=1 boundary with operand address changing mid-access.
        addr1 = 16'h1111; req = 3'b010;
        cyc(1); req = 3'b000;
        cyc(1); addr1 = 16'h2222;
        cyc(1);
        chk("ac1_ack_b", 32'(ack[1]), 32'h2);
        chk("ac1_mar_b", 32'(mar[1]), 32'h1111);
        chk("ac1_mar_a", 32'(mar[0]), 32'h1111);
        cyc(1);
        chk("ac1_ack_a", 32'(ack[0]), 32'h2);
        cyc(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
